// File: rtl/dp_record_reader.sv
// dp_record_reader
// Drains processed-cycle records from the DP system FIFO and streams each
// record as a byte frame on a valid/ready link:
//   SYNC, rec[7:0], rec[15:8], rec[23:16], rec[31:24], {pad, rec[37:32]} [, checksum]
// Record layout: {MaxTime[m-1:0], MaxAmpl[n-1:0], ZeroOffset[n-1:0], CycleNumber[k-1:0]}.
// Optional feature macro: DPREC_CHECKSUM_EN appends an XOR checksum of the
// five record bytes as a seventh byte, which then carries TxLast.
module dp_record_reader #(
  parameter int         n      = 8,
  parameter int         m      = 10,
  parameter int         k      = 12,
  parameter int         RD_LAT = 1,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               i_Enable,
  input  logic               i_FifoEmpty,
  input  logic [m+2*n+k-1:0] i_FifoReadData,
  output logic               o_FifoReadEna,
  output logic [7:0]         o_TxData,
  output logic               o_TxValid,
  output logic               o_TxLast,
  input  logic               i_TxReady,
  output logic [15:0]        o_FrameCount,
  output logic               o_Busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_LOAD = 3'd3,
    ST_SYNC = 3'd4,
`ifdef DPREC_CHECKSUM_EN
    ST_DATA = 3'd5,
    ST_CSUM = 3'd6
`else
    ST_DATA = 3'd5
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;
  logic [39:0] r_shift;
  logic [39:0] w_shift_nxt;
  logic [39:0] w_capture;
  logic [7:0]  r_tx_data;
  logic [7:0]  w_data_nxt;
  logic        r_tx_valid;
  logic        w_valid_nxt;
  logic        r_tx_last;
  logic        w_last_nxt;
  logic        r_fifo_rd;
  logic        w_rd_nxt;
  logic        r_busy;
  logic [15:0] r_frame_count;
  logic        w_cnt_inc;
  logic        w_fire;
`ifdef DPREC_CHECKSUM_EN
  logic [7:0]  r_csum;
  logic [7:0]  w_csum_nxt;
`endif

  // Record zero-extended into the 40-bit byte shifter; a byte moves only on valid&ready.
  assign w_capture = 40'(i_FifoReadData);
  assign w_fire    = r_tx_valid & i_TxReady;

  // FSM state register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and next values of every registered output/datapath field.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_tx_data;
    w_valid_nxt = r_tx_valid;
    w_last_nxt  = r_tx_last;
    w_rd_nxt    = 1'b0;
    w_cnt_inc   = 1'b0;
`ifdef DPREC_CHECKSUM_EN
    w_csum_nxt  = r_csum;
`endif
    case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        // FifoEmpty is only looked at here, so the read strobe cannot hit an empty FIFO.
        if (i_Enable && !i_FifoEmpty) begin
          w_state_nxt = ST_READ;
          w_rd_nxt    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        // Show-ahead FIFO presents data alongside the strobe, so capture now.
        if (RD_LAT == 0) begin
          w_shift_nxt = w_capture;
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (RD_LAT != 0) begin
          w_shift_nxt = w_capture;
        end else begin
          w_shift_nxt = r_shift;
        end
        w_state_nxt = ST_SYNC;
        w_data_nxt  = SYNC;
        w_valid_nxt = 1'b1;
        w_last_nxt  = 1'b0;
        w_idx_nxt   = 3'd0;
`ifdef DPREC_CHECKSUM_EN
        w_csum_nxt  = 8'h00;
`endif
      end
      ST_SYNC: begin
        if (w_fire) begin
          w_state_nxt = ST_DATA;
          w_data_nxt  = r_shift[7:0];
        end else begin
          w_state_nxt = ST_SYNC;
        end
      end
      ST_DATA: begin
        if (w_fire) begin
`ifdef DPREC_CHECKSUM_EN
          w_csum_nxt = r_csum ^ r_tx_data;
`endif
          if (r_idx == 3'd4) begin
`ifdef DPREC_CHECKSUM_EN
            w_state_nxt = ST_CSUM;
            w_data_nxt  = r_csum ^ r_tx_data;
            w_last_nxt  = 1'b1;
`else
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_cnt_inc   = 1'b1;
`endif
          end else begin
            // Shifter low byte always mirrors the byte on the link; the next one sits above it.
            w_idx_nxt   = r_idx + 3'd1;
            w_shift_nxt = r_shift >> 8;
            w_data_nxt  = r_shift[15:8];
`ifdef DPREC_CHECKSUM_EN
            w_last_nxt  = 1'b0;
`else
            w_last_nxt  = (r_idx == 3'd3);
`endif
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
`ifdef DPREC_CHECKSUM_EN
      ST_CSUM: begin
        if (w_fire) begin
          w_state_nxt = ST_IDLE;
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_cnt_inc   = 1'b1;
        end else begin
          w_state_nxt = ST_CSUM;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  // Registered datapath and outputs; reset aborts any frame in flight.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_idx         <= 3'd0;
      r_shift       <= 40'd0;
      r_tx_data     <= 8'd0;
      r_tx_valid    <= 1'b0;
      r_tx_last     <= 1'b0;
      r_fifo_rd     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= 16'd0;
`ifdef DPREC_CHECKSUM_EN
      r_csum        <= 8'd0;
`endif
    end else begin
      r_idx         <= w_idx_nxt;
      r_shift       <= w_shift_nxt;
      r_tx_data     <= w_data_nxt;
      r_tx_valid    <= w_valid_nxt;
      r_tx_last     <= w_last_nxt;
      r_fifo_rd     <= w_rd_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_frame_count <= r_frame_count + {15'd0, w_cnt_inc};
`ifdef DPREC_CHECKSUM_EN
      r_csum        <= w_csum_nxt;
`endif
    end
  end

  assign o_FifoReadEna = r_fifo_rd;
  assign o_TxData      = r_tx_data;
  assign o_TxValid     = r_tx_valid;
  assign o_TxLast      = r_tx_last;
  assign o_FrameCount  = r_frame_count;
  assign o_Busy        = r_busy;

endmodule
